// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: IM SRAM read port, decode redirect port and decode
// drain handshake, with the fetch unit on the master side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   im_addr;
  logic [31:0]   im_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [CW-1:0] occupancy;

  modport master (
    output im_addr,
    input  im_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output occupancy
  );

  modport slave (
    input  im_addr,
    output im_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues one IM read per cycle when
// space is reserved, and buffers {inst, pc} pairs in a DEPTH-entry FIFO.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   inflight_pc_r;
  logic          inflight_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [63:0]   mem_r [DEPTH];

  logic          empty_s;
  logic          out_valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   demand_s;

  // Per-cycle handshake and issue decisions
  always_comb begin
    empty_s     = (count_r == {CW{1'b0}});
    out_valid_s = !empty_s && !bus.redirect_valid;
    pop_s       = out_valid_s && bus.out_ready;
    push_s      = inflight_r && !bus.redirect_valid;
    // one guard bit keeps count + inflight - pop from wrapping
    demand_s    = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    issue_s     = !bus.redirect_valid && (demand_s < DEPTH_W);
  end

  // Fetch PC, in-flight read tracking, FIFO pointers and entry count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= {bus.redirect_pc[31:2], 2'b00};
      inflight_r <= 1'b0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + 32'd4;
        inflight_r    <= 1'b1;
        inflight_pc_r <= fetch_pc_r;
      end else begin
        inflight_r <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; visibility is gated by count so contents need no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.im_data, inflight_pc_r};
    end
  end

  assign bus.im_addr   = fetch_pc_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_inst  = mem_r[rd_ptr_r][63:32];
  assign bus.out_pc    = mem_r[rd_ptr_r][31:0];
  assign bus.occupancy = count_r;

  // The issue rule reserves a slot for every read, so a push never meets a full FIFO
  push_not_full_a: assert property (@(posedge clk) disable iff (!rst)
    push_s |-> (count_r < DEPTH_C))
    else $error("fetch_queue: push into full FIFO");
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: IM model returns 0x1000_0000 + word index,
// each scenario task checks its own hand-derived cycle-by-cycle expectations.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous read-only SRAM, always enabled
  always @(posedge clk) bus.im_data <= word_of(bus.im_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Holds reset for two cycles and releases it on a falling edge (cycle 0).
  task automatic do_reset(input logic rdy);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.out_ready      = rdy;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Expects to be entered on the falling edge of cycle 0 with out_ready high.
  task automatic run_stream(input string tag, input int ncyc);
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_addr = 32'(4 * k);
      n_cmp++;
      if (bus.im_addr !== exp_addr) begin
        n_err++;
        $display("FAIL %s_im_addr cyc %0d: got %h want %h", tag, k, bus.im_addr, exp_addr);
      end
      n_cmp++;
      if (bus.out_valid !== (k >= 2)) begin
        n_err++;
        $display("FAIL %s_valid cyc %0d: got %b want %b", tag, k, bus.out_valid, (k >= 2));
      end
      if (k >= 2) begin
        exp_pc = 32'(4 * (k - 2));
        n_cmp++;
        if (bus.out_pc !== exp_pc) begin
          n_err++;
          $display("FAIL %s_pc cyc %0d: got %h want %h", tag, k, bus.out_pc, exp_pc);
        end
        n_cmp++;
        if (bus.out_inst !== word_of(exp_pc)) begin
          n_err++;
          $display("FAIL %s_inst cyc %0d: got %h want %h", tag, k, bus.out_inst, word_of(exp_pc));
        end
        n_cmp++;
        if (bus.occupancy !== 3'd1) begin
          n_err++;
          $display("FAIL %s_occ cyc %0d: got %0d want 1", tag, k, bus.occupancy);
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.out_ready      = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.im_addr !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL reset_im_addr: got %h want 00000000", bus.im_addr);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL reset_occ: got %0d want 0", bus.occupancy);
    end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    run_stream("stream", 12);
  endtask

  task automatic test_backpressure;
    logic [2:0]  exp_occ;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_occ  = (k < 2) ? 3'd0 : ((k - 1) > 4 ? 3'd4 : 3'(k - 1));
      exp_addr = (k > 4) ? 32'h0000_0010 : 32'(4 * k);
      n_cmp++;
      if (bus.occupancy !== exp_occ) begin
        n_err++;
        $display("FAIL bp_occ cyc %0d: got %0d want %0d", k, bus.occupancy, exp_occ);
      end
      n_cmp++;
      if (bus.im_addr !== exp_addr) begin
        n_err++;
        $display("FAIL bp_im_addr cyc %0d: got %h want %h", k, bus.im_addr, exp_addr);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      exp_pc = 32'(4 * j);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_release_valid idx %0d: got %b want 1", j, bus.out_valid);
      end
      n_cmp++;
      if (bus.out_pc !== exp_pc) begin
        n_err++;
        $display("FAIL bp_release_pc idx %0d: got %h want %h", j, bus.out_pc, exp_pc);
      end
      n_cmp++;
      if (bus.out_inst !== word_of(exp_pc)) begin
        n_err++;
        $display("FAIL bp_release_inst idx %0d: got %h want %h", j, bus.out_inst, word_of(exp_pc));
      end
    end
  endtask

  // Redirect issued in cycle t (at the current falling edge); checks t..t+ncyc.
  task automatic redirect_and_check(input string tag, input logic [31:0] rpc,
                                    input logic [2:0] occ_at_t, input int ncyc);
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    base = {rpc[31:2], 2'b00};
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = rpc;
    bus.out_ready      = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_valid_t: got %b want 0", tag, bus.out_valid);
    end
    n_cmp++;
    if (bus.occupancy !== occ_at_t) begin
      n_err++;
      $display("FAIL %s_occ_t: got %0d want %0d", tag, bus.occupancy, occ_at_t);
    end
    for (int d = 1; d <= ncyc; d++) begin
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      if (d <= 3) begin
        exp_addr = base + 32'(4 * (d - 1));
        n_cmp++;
        if (bus.im_addr !== exp_addr) begin
          n_err++;
          $display("FAIL %s_im_addr t+%0d: got %h want %h", tag, d, bus.im_addr, exp_addr);
        end
      end
      n_cmp++;
      if (bus.out_valid !== (d >= 3)) begin
        n_err++;
        $display("FAIL %s_valid t+%0d: got %b want %b", tag, d, bus.out_valid, (d >= 3));
      end
      if (d < 3) begin
        n_cmp++;
        if (bus.occupancy !== 3'd0) begin
          n_err++;
          $display("FAIL %s_occ t+%0d: got %0d want 0", tag, d, bus.occupancy);
        end
      end else begin
        exp_pc = base + 32'(4 * (d - 3));
        n_cmp++;
        if (bus.out_pc !== exp_pc) begin
          n_err++;
          $display("FAIL %s_pc t+%0d: got %h want %h", tag, d, bus.out_pc, exp_pc);
        end
        n_cmp++;
        if (bus.out_inst !== word_of(exp_pc)) begin
          n_err++;
          $display("FAIL %s_inst t+%0d: got %h want %h", tag, d, bus.out_inst, word_of(exp_pc));
        end
      end
    end
  endtask

  task automatic test_redirect_full;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    redirect_and_check("redir_full", 32'h0000_0203, 3'd3, 7);
  endtask

  task automatic test_redirect_pop_push;
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    redirect_and_check("redir_pop", 32'h0000_1000, 3'd1, 5);
  endtask

  task automatic test_wrap;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    redirect_and_check("wrap", 32'hFFFF_FFF8, 3'd1, 6);
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.occupancy !== 3'd3) begin
      n_err++;
      $display("FAIL areset_pre_occ: got %0d want 3", bus.occupancy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.im_addr !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL areset_im_addr: got %h want 00000000", bus.im_addr);
    end
    n_cmp++;
    if (bus.occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL areset_occ: got %0d want 0", bus.occupancy);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run_stream("areset_restart", 12);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop_push();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch unit between the instruction-memory SRAM wrapper and the CPU decode stage. It owns the fetch PC, drives the IM read address every cycle, captures the IM read data one cycle later, and buffers instruction/PC pairs in a DEPTH-entry FIFO. Decode drains the FIFO over a valid/ready handshake and can redirect fetch through a flush port.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- im_addr  out  32  IM read byte address (SRAM uses [15:2]); equals fetch_pc register
- im_data  in  32  IM read data; valid 1 cycle after im_addr presented (SRAM always enabled, read-only)
- redirect_valid  in  1  flush FIFO, kill in-flight read, restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- out_valid  out  1  head entry available; = !empty && !redirect_valid
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  32  head instruction
- out_pc  out  32  head instruction byte address
- occupancy  out  $clog2(DEPTH+1)  current FIFO entry count

## Operation
- State: fetch_pc[31:0], inflight (1b), inflight_pc[31:0], FIFO (DEPTH × 64b), wr/rd pointers ($clog2(DEPTH) bits, natural wrap), count.
- pop = out_valid && out_ready.
- issue = !redirect_valid && (count + inflight − pop) < DEPTH; compare at width $clog2(DEPTH+1)+1 to avoid underflow.
- Issue: fetch_pc ← fetch_pc + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), inflight ← 1, inflight_pc ← fetch_pc. No issue: fetch_pc holds, inflight ← 0. SRAM still reads; data for non-issued cycles is discarded.
- Response: if inflight==1 and !redirect_valid, push {im_data, inflight_pc} at wr_ptr.
- Push and pop in same cycle: count unchanged, both pointers advance. Push never occurs when full (guaranteed by issue rule; assertion required).
- Redirect (highest priority): count ← 0, pointers ← 0, inflight ← 0, fetch_pc ← {redirect_pc[31:2], 2'b00}. Same-cycle push and pop suppressed; out_valid forced low that cycle.
- Reset (async, any time): fetch_pc ← RESET_PC, inflight ← 0, count ← 0, pointers ← 0. FIFO storage not reset.

## Timing
- Reset values: im_addr = RESET_PC, out_valid = 0, occupancy = 0; out_inst/out_pc undefined while out_valid=0.
- Cycle 0 = first cycle after rst deasserts: RESET_PC issued; cycle 1 im_data captured; cycle 2 out_valid=1, out_pc=RESET_PC.
- Redirect in cycle t: im_addr = redirect_pc in t+1; out_valid=1 with out_pc=redirect_pc first in t+3; out_valid=0 in t..t+2.
- Steady state with out_ready held high: one instruction per cycle, no bubbles, occupancy settles at 1.
- out_ready low: FIFO fills to DEPTH, then issue stops; im_addr holds next un-issued PC. Resume: first pop enables issue same cycle; no entry lost or duplicated.
- out_valid/out_inst/out_pc depend combinationally only on FIFO head and redirect_valid, never on out_ready.

## Test plan
- Reset stream: IM word n = 0x1000_0000+n, RESET_PC=0, out_ready=1 -> out_valid from cycle 2, out_pc 0,4,8,… every cycle, out_inst matching.
- Backpressure: out_ready=0 from cycle 0 -> occupancy reaches DEPTH=4, stays; im_addr frozen at 0x10; release -> PCs 0x0..0x1C delivered in order, no gaps/duplicates.
- Redirect with full FIFO and inflight read, redirect_pc=0x0000_0203 -> out_valid=0 for 3 cycles, then out_pc=0x200, 0x204,…; no stale entries.
- Redirect coincident with pop and push -> occupancy 0 next cycle, popped entry not counted as delivered (out_valid was 0).
- Wrap: redirect to 0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset mid-stream (rst low between edges, occupancy 3) -> out_valid=0 and im_addr=RESET_PC immediately; restart identical to first scenario.
